debounce_multi: RTL
===================

# debounce_multi

Parametrised multi-channel debouncer for mechanical switches and push-buttons. Each channel has a 2-flop-or-deeper synchroniser and a per-channel debounce state machine; all channels share one sample-tick generator. Besides the clean level `db`, the block emits one-cycle `db_rise`/`db_fall` pulses for edge-triggered consumers such as counters and FSM step inputs. It sits directly behind the board switch/button pins and feeds all user-input logic.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `TICK_DIV`, 500000: clock cycles per sample tick (≥1); the default gives 10 ms at 50 MHz.
- `STABLE_TICKS`, 3: consecutive ticks an input must hold a new level before `db` follows (≥1).
- `SYNC_STAGES`, 2: synchroniser depth (≥2).
- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: asynchronous, active-high reset.
- `sw`, in, CHANNELS: raw asynchronous switch inputs.
- `db`, out, CHANNELS: debounced levels.
- `db_rise`, out, CHANNELS: one-cycle pulse, high in the first cycle `db[i]` is 1.
- `db_fall`, out, CHANNELS: one-cycle pulse, high in the first cycle `db[i]` is 0.

## Operation
- **Synchroniser:** `sw[i]` passes through a `SYNC_STAGES`-deep flop chain, which produces `s[i]`. Only `s[i]` is used downstream.
- **Tick generator:**
  - Free-running counter, `$clog2(TICK_DIV)` bits wide (minimum 1).
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for one cycle when the count equals TICK_DIV-1.
  - With TICK_DIV=1, `tick` is constantly high.
- **Per-channel FSM:** states LOW, WAIT_HI, HIGH, WAIT_LO. Stability counter `cnt` is `$clog2(STABLE_TICKS+1)` bits.
  - LOW: if `s`=1, go to WAIT_HI with `cnt`=0.
  - WAIT_HI: if `s`=0, go to LOW. Otherwise, on `tick`, if `cnt`==STABLE_TICKS-1 go to HIGH, else increment `cnt`.
  - HIGH: if `s`=0, go to WAIT_LO with `cnt`=0.
  - WAIT_LO: if `s`=1, go to HIGH. Otherwise, on `tick`, if `cnt`==STABLE_TICKS-1 go to LOW, else increment `cnt`.
  - Illegal encodings go to LOW.
- **Outputs:**
  - `db` is a Moore output from the registered state: 1 in HIGH and WAIT_LO, 0 in LOW and WAIT_HI.
  - `db_d` is `db` delayed by one register.
  - `db_rise` = `db & ~db_d`; `db_fall` = `~db & db_d`.
- **Boundary conditions:**
  - If a level reversal and `tick` occur in the same cycle, the reversal wins. `cnt` does not advance and the FSM returns to its stable state.
  - A glitch shorter than the debounce window causes no `db` change and no pulses.
  - Channels are fully independent; simultaneous activity on all channels is legal.

## Timing
- **Reset values:** all synchroniser flops 0, tick counter 0, every FSM in LOW with `cnt`=0, `db_d`=0. Outputs `db`, `db_rise` and `db_fall` are all 0.
- **Reset mid-operation:** asserting reset mid-wait aborts the wait immediately. After release the channel re-qualifies from LOW.
- **Latency:** count clock edges from the first edge that samples a new stable `sw` level as edge 0. The state becomes HIGH, and `db` goes to 1, after edge SYNC_STAGES + (STABLE_TICKS-1)·TICK_DIV + d, where d ∈ [1, TICK_DIV] depends on tick phase. Falling latency is symmetric.
- **Pulses:** `db_rise`/`db_fall` are exactly one cycle wide and coincide with the first cycle of the new `db` level.

## Structure
- Package `debounce_pkg` holds the `typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_t`.
- Sub-module `debounce_channel`: one channel, containing the synchroniser, FSM, `cnt`, `db_d` and the pulse logic. It receives `tick` as an input.
- The top level contains the tick generator and a generate loop over CHANNELS.

## Test plan
All scenarios use CHANNELS=2, TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2 unless stated otherwise.
- **Clean press:** `sw[0]` 0→1 and held -> `db[0]` rises between edge 11 and edge 14. `db_rise[0]` is high for exactly 1 cycle. `db[1]`, `db_fall` and `db_rise[1]` stay 0.
- **Clean release:** after press, `sw[0]` 1→0 and held -> `db[0]` falls between edge 11 and edge 14. `db_fall[0]` is a 1-cycle pulse.
- **Bounce:** `sw[0]` toggles high for 5 cycles, low for 3, high for 6, low -> `db[0]` stays 0 throughout, with no `db_rise[0]`.
- **Independence:** `sw[0]` and `sw[1]` rise 7 cycles apart -> each `db` obeys its own 11–14 edge window, and the pulses occur on separate cycles.
- **Reset mid-wait:** reset is pulsed 1 cycle while channel 0 is in WAIT_HI with `sw[0]`=1 held -> all outputs are 0 during reset. `db[0]` rises 11–14 edges after reset release, with no extra pulse.
- **TICK_DIV=1, STABLE_TICKS=1:** a `sw[0]` step -> `db[0]` rises exactly 3 edges after the step edge, and a 1-cycle glitch is still rejected.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW     = 2'b00,
      WAIT_HI = 2'b01,
      HIGH    = 2'b10,
      WAIT_LO = 2'b11
   } db_state_t;

   // Counter width for a range of v values, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, qualification FSM and edge pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 3,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw,
   output logic db,
   output logic db_rise,
   output logic db_fall
);

   localparam int                CNT_W    = clog2_min1(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   db_state_t              state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   db_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge, which keeps the chain a chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOW;
         cnt   <= '0;
         db_d  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         db_d  <= db;
      end
   end

   // A level reversal is tested before tick, so it wins when both coincide.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         LOW: begin
            if (s) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_nxt = LOW;
            end else if (tick) begin
               if (cnt == CNT_LAST) state_nxt = HIGH;
               else                 cnt_nxt   = cnt + CNT_ONE;
            end
         end
         HIGH: begin
            if (!s) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_nxt = HIGH;
            end else if (tick) begin
               if (cnt == CNT_LAST) state_nxt = LOW;
               else                 cnt_nxt   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign db      = (state == HIGH) || (state == WAIT_LO);
   assign db_rise = db & ~db_d;
   assign db_fall = ~db & db_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: one shared sample-tick generator feeding
// independent per-channel debounce state machines.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 500000,
   parameter int STABLE_TICKS = 3,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] sw,
   output logic [CHANNELS-1:0] db,
   output logic [CHANNELS-1:0] db_rise,
   output logic [CHANNELS-1:0] db_fall
);

   localparam int                TICK_W    = clog2_min1(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   // With TICK_DIV of 1 the counter sits at 0 and tick stays high.
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_ONE;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .SYNC_STAGES  (SYNC_STAGES)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .tick    (tick),
         .sw      (sw[i]),
         .db      (db[i]),
         .db_rise (db_rise[i]),
         .db_fall (db_fall[i])
      );
   end

endmodule
